pic_port_uart: RTL

Serial transmit stage that sits directly downstream of the PIC16 core's GPIO ports on the NEXYS4 DDR board. Firmware writes a byte to RB and pulses an RA bit. The block captures the byte into a small FIFO and shifts it out as 8N1 UART on a board pin. FULL is fed back to an RA input so firmware can poll for flow control. It runs on the PIC clock (PICCLK) and is reset by the same low-active PLL-locked reset as the core.

---
 rtl/pic_port_uart.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pic_port_uart.sv
// pic_port_uart: serial transmit stage fed from the PIC16 GPIO ports.
// Firmware puts a byte on RB and pulses RA[0]. Each rising edge of the strobe
// pushes that byte into a small FIFO. The FIFO drains as 8N1 UART on TXD.
// FULL goes back to RA[1] so firmware can poll before each write.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line high; pops the FIFO head on the next edge when not empty
// S_START | start bit, line low for DIV cycles
// S_DATA  | data bits, LSB first, DIV cycles each
// S_STOP  | stop bit, line high for DIV cycles
module pic_port_uart #(
  parameter int CLK_HZ = 70000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] PORT_D,
  input  logic       PORT_STB,
  output logic       FULL,
  output logic       BUSY,
  output logic       OVR,
  output logic       TXD
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DIV);

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            txd_q, txd_d;

  logic            stb_d;
  logic            ovr_q;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;

  logic            push_req, push, pop, full;

  // Fullness is judged before any same-cycle pop, so a push that coincides
  // with the pop of a full FIFO is still refused.
  assign push_req = PORT_STB & ~stb_d;
  assign full     = (count == CNT_FULL);
  assign push     = push_req & ~full;
  assign pop      = (state_q == S_IDLE) && (count != '0);

  assign FULL = full;
  assign BUSY = (state_q != S_IDLE) || (count != '0);
  assign OVR  = ovr_q;
  assign TXD  = txd_q;

  // Strobe edge detect. stb_d resets high so a strobe held across reset never pushes.
  // Overrun flag is sticky until reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stb_d <= 1'b1;
      ovr_q <= 1'b0;
    end else begin
      stb_d <= PORT_STB;
      if (push_req && full) ovr_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= PORT_D;
  end

  // Transmit FSM state register; TXD is registered so the line never glitches.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic: the baud counter runs DIV-1 down to 0 in every active state.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    txd_d   = 1'b1;

    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        if (pop) begin
          shreg_d = mem[rptr];
          bidx_d  = '0;
          bcnt_d  = BAUD_LAST;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bcnt_q == '0) begin
          bcnt_d  = BAUD_LAST;
          bidx_d  = '0;
          state_d = S_DATA;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      S_DATA: begin
        if (bcnt_q == '0) begin
          bcnt_d  = BAUD_LAST;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bidx_q == 3'd7) state_d = S_STOP;
          else                bidx_d  = bidx_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      S_STOP: begin
        if (bcnt_q == '0) begin
          bcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      default: begin
        bcnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
  end

endmodule
